text_console: RTL and testbench

//  Terminal-style writer feeding the character generator's flattened text buffer.
//  - Accepts one byte per valid/ready handshake from the CPU I/O port.
//  - Handles printable characters, newline, backspace and clear-screen.
//  - Keeps a cursor and scrolls the screen up one row when output runs past the last row.
//  - Drives text_buffer directly: cell (r,c) = bits [(r*COLUMNS+c)*8 +: 8].

---
 rtl/text_console.sv | 148 ++++++++++++++
 tb/tb_text_console.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// Terminal-style writer for the character generator text buffer.
// Prints, handles LF/BS/FF, and scrolls one row when output passes the last row.
module text_console #(
    parameter int COLUMNS = 16,
    parameter int ROWS    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                char_in,
    input  logic                      char_valid,
    output logic                      char_ready,
    output logic [COLUMNS*ROWS*8:0]   text_buffer,
    output logic [6:0]                cursor_col,
    output logic [4:0]                cursor_row
);

    localparam int N  = COLUMNS * ROWS;
    localparam int IW = $clog2(N + 1);
    localparam int BW = $clog2(N * 8);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCROLL = 2'd1;
    localparam logic [1:0] S_CLEAR  = 2'd2;

    localparam logic [7:0]    BLANK     = 8'h20;
    localparam logic [6:0]    COL_LAST  = 7'(COLUMNS - 1);
    localparam logic [4:0]    ROW_LAST  = 5'(ROWS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [IW-1:0] IDX_SPLIT = IW'(N - COLUMNS);
    localparam logic [IW-1:0] ROW_STEP  = IW'(COLUMNS);

    logic [N*8-1:0] cells_q, cells_d;
    logic [1:0]     state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [6:0]     col_q, col_d;
    logic [4:0]     row_q, row_d;

    logic [IW-1:0]  cur_idx, prev_idx, src_idx;
    logic [BW-1:0]  cur_bit, prev_bit, idx_bit, src_bit;
    logic           accept, printable;

    assign cur_idx   = IW'(row_q) * ROW_STEP + IW'(col_q);
    assign prev_idx  = cur_idx - 1'b1;
    assign src_idx   = idx_q + ROW_STEP;
    assign cur_bit   = BW'({cur_idx, 3'b000});
    assign prev_bit  = BW'({prev_idx, 3'b000});
    assign idx_bit   = BW'({idx_q, 3'b000});
    assign src_bit   = BW'({src_idx, 3'b000});
    assign accept    = char_valid && (state_q == S_IDLE);
    assign printable = (char_in >= 8'h20) && (char_in <= 8'h7E);

    always_comb begin
        cells_d = cells_q;
        state_d = state_q;
        idx_d   = idx_q;
        col_d   = col_q;
        row_d   = row_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        printable: begin
                            cells_d[cur_bit +: 8] = char_in;
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                if (row_q == ROW_LAST) begin
                                    state_d = S_SCROLL;
                                    idx_d   = '0;
                                end else begin
                                    row_d = row_q + 1'b1;
                                end
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                        (char_in == 8'h0A): begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                state_d = S_SCROLL;
                                idx_d   = '0;
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end
                        (char_in == 8'h08): begin
                            // Previous cell is always linear index-1, even across a row wrap
                            if (cur_idx != '0) begin
                                cells_d[prev_bit +: 8] = BLANK;
                                if (col_q != '0) begin
                                    col_d = col_q - 1'b1;
                                end else begin
                                    col_d = COL_LAST;
                                    row_d = row_q - 1'b1;
                                end
                            end
                        end
                        (char_in == 8'h0C): begin
                            col_d   = '0;
                            row_d   = '0;
                            state_d = S_CLEAR;
                            idx_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_SCROLL, S_CLEAR: begin
                if (state_q == S_SCROLL && idx_q < IDX_SPLIT) begin
                    cells_d[idx_bit +: 8] = cells_q[src_bit +: 8];
                end else begin
                    cells_d[idx_bit +: 8] = BLANK;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cells_q <= {N{BLANK}};
            state_q <= S_IDLE;
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            cells_q <= cells_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    assign text_buffer = {1'b0, cells_q};
    assign char_ready  = (state_q == S_IDLE);
    assign cursor_col  = col_q;
    assign cursor_row  = row_q;

endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: stimulus queues hand-computed results,
// a negedge monitor pops them as each accepted byte completes.
module tb_text_console;

    localparam int COLUMNS = 16;
    localparam int ROWS    = 4;
    localparam int N       = COLUMNS * ROWS;
    localparam int W       = N * 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   char_in = 8'h00;
    logic         char_valid = 1'b0;
    logic         char_ready;
    logic [W:0]   text_buffer;
    logic [6:0]   cursor_col;
    logic [4:0]   cursor_row;

    always #5 clk = ~clk;

    text_console #(.COLUMNS(COLUMNS), .ROWS(ROWS)) dut (
        .clk         (clk),
        .reset       (reset),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .text_buffer (text_buffer),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row)
    );

    typedef struct {
        logic [6:0]   col;
        logic [4:0]   row;
        int           busy;
        logic [W-1:0] buf_v;
        logic [W-1:0] mask;
        bit           abort;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] eb, em;
    bit           armed = 1'b0;
    int           busy_cnt = 0;
    exp_t         cur;

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic blank_all();
        eb = {N{8'h20}};
        em = '1;
    endtask

    task automatic setc(input int i, input logic [7:0] v);
        eb[i*8 +: 8] = v;
        em[i*8 +: 8] = 8'hFF;
    endtask

    task automatic push_exp(input int col, input int row, input int busy, input bit abort);
        exp_t e;
        e.col   = 7'(col);
        e.row   = 5'(row);
        e.busy  = busy;
        e.buf_v = eb;
        e.mask  = em;
        e.abort = abort;
        sbq.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        while (!char_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!char_ready) begin
            checks++;
            errors++;
            $display("FAIL send_wait: ready still %0b after %0d cycles, required 1", char_ready, t);
        end
        char_in    = b;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || armed) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results pending, required 0", sbq.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        blank_all();
        chk({tag, "_ready"}, char_ready, 1'b1);
        chk({tag, "_col"}, cursor_col, 0);
        chk({tag, "_row"}, cursor_row, 0);
        chk({tag, "_buf"}, text_buffer, {1'b0, eb});
    endtask

    // Monitor: arms on an accepted byte, counts busy cycles, compares when ready returns
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (armed) begin
                    armed = 1'b0;
                    if (sbq.size() > 0) begin
                        cur = sbq.pop_front();
                        chk("scroll_abort", cur.abort, 1'b1);
                    end
                end
            end else begin
                if (armed) begin
                    if (!char_ready) begin
                        busy_cnt++;
                        if (busy_cnt > 200) begin
                            chk("busy_timeout", busy_cnt, 200);
                            armed = 1'b0;
                            if (sbq.size() > 0) cur = sbq.pop_front();
                        end
                    end else begin
                        armed = 1'b0;
                        if (sbq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected: output with no queued result, required none");
                        end else begin
                            cur = sbq.pop_front();
                            chk("col", cursor_col, cur.col);
                            chk("row", cursor_row, cur.row);
                            chk("busy", busy_cnt, cur.busy);
                            chk("abort_flag", cur.abort, 1'b0);
                            chk("buf", text_buffer & {1'b1, cur.mask}, {1'b0, cur.buf_v & cur.mask});
                        end
                    end
                end
                if (!armed && char_valid && char_ready) begin
                    armed    = 1'b1;
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("reset");

        // Two printables
        blank_all();
        setc(0, 8'h41); push_exp(1, 0, 0, 0); send(8'h41);
        setc(1, 8'h42); push_exp(2, 0, 0, 0); send(8'h42);
        drain();

        // Full row wraps to next row
        do_reset(); blank_all();
        for (int i = 0; i < 16; i++) begin
            setc(i, 8'h58);
            push_exp((i == 15) ? 0 : i + 1, (i == 15) ? 1 : 0, 0, 0);
            send(8'h58);
        end
        drain();

        // LF on last row scrolls
        do_reset(); blank_all();
        setc(0, 8'h50);  push_exp(1, 0, 0, 0); send(8'h50);
        push_exp(0, 1, 0, 0); send(8'h0A);
        setc(16, 8'h51); push_exp(1, 1, 0, 0); send(8'h51);
        push_exp(0, 2, 0, 0); send(8'h0A);
        setc(32, 8'h52); push_exp(1, 2, 0, 0); send(8'h52);
        push_exp(0, 3, 0, 0); send(8'h0A);
        for (int i = 0; i < 5; i++) begin
            setc(48 + i, 8'h53);
            push_exp(i + 1, 3, 0, 0);
            send(8'h53);
        end
        blank_all();
        setc(0, 8'h51); setc(16, 8'h52);
        for (int i = 32; i < 37; i++) setc(i, 8'h53);
        push_exp(0, 3, 64, 0); send(8'h0A);
        drain();

        // Print into last cell scrolls, then form feed clears
        do_reset(); blank_all();
        for (int i = 0; i < 63; i++) begin
            setc(i, 8'h5A);
            push_exp((i + 1) % 16, (i + 1) / 16, 0, 0);
            send(8'h5A);
        end
        blank_all();
        for (int i = 0; i < 47; i++) setc(i, 8'h5A);
        setc(47, 8'h59);
        push_exp(0, 3, 64, 0); send(8'h59);
        blank_all();
        push_exp(0, 0, 64, 0); send(8'h0C);
        drain();

        // Backspace across a row boundary
        do_reset(); blank_all();
        for (int i = 0; i < 16; i++) begin
            setc(i, 8'h42);
            push_exp((i == 15) ? 0 : i + 1, (i == 15) ? 1 : 0, 0, 0);
            send(8'h42);
        end
        setc(15, 8'h20); push_exp(15, 0, 0, 0); send(8'h08);
        setc(14, 8'h20); push_exp(14, 0, 0, 0); send(8'h08);
        drain();

        // Backspace at home does nothing
        do_reset(); blank_all();
        setc(0, 8'h43); push_exp(1, 0, 0, 0); send(8'h43);
        setc(0, 8'h20); push_exp(0, 0, 0, 0); send(8'h08);
        push_exp(0, 0, 0, 0); send(8'h08);
        drain();

        // Reset in the middle of a scroll
        do_reset(); blank_all();
        for (int i = 0; i < 13; i++) begin
            setc(i, 8'h44);
            push_exp(i + 1, 0, 0, 0);
            send(8'h44);
        end
        push_exp(0, 1, 0, 0); send(8'h0A);
        push_exp(0, 2, 0, 0); send(8'h0A);
        push_exp(0, 3, 0, 0); send(8'h0A);
        push_exp(0, 3, 64, 1); send(8'h0A);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("midscroll");

        // Non-printing bytes are consumed without effect
        blank_all();
        push_exp(0, 0, 0, 0); send(8'h07);
        push_exp(0, 0, 0, 0); send(8'hFF);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
